// File: rtl/fully_connected.sv
// Binarized dense layer: per-node XNOR-popcount of fan_in against a binary
// weight vector plus an unsigned bias, registered through a 2-stage pipeline.
module fully_connected #(
    parameter int unsigned N_IN   = 960,
    parameter int unsigned N_OUT  = 10,
    parameter int unsigned W_BIAS = 8,
    parameter int unsigned W_OUT  = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IN-1:0]   fan_in,
    input  logic [W_BIAS-1:0] weights        [N_OUT],
    input  logic [N_IN-1:0]   binary_weights [N_OUT],
    output logic [W_OUT-1:0]  fan_out        [N_OUT]
);

    localparam int unsigned W_POP  = $clog2(N_IN + 1);
    localparam int unsigned LVLS   = $clog2(N_IN);
    localparam int unsigned N_LEAF = 1 << LVLS;
    localparam int unsigned W_TREE = LVLS + 1;

    for (genvar n = 0; n < N_OUT; n++) begin : g_node
        logic [N_IN-1:0]   xnor_result;
        logic [W_TREE-1:0] tree [1:2*N_LEAF-1];
        logic [W_POP-1:0]  pop_d,  pop_q;
        logic [W_BIAS-1:0] bias_d, bias_q;
        logic [W_OUT-1:0]  sum_d,  sum_q;

        assign xnor_result = ~(fan_in ^ binary_weights[n]);

        // Heap-indexed balanced adder tree; leaves beyond N_IN are tied off to zero.
        for (genvar j = 0; j < N_LEAF; j++) begin : g_leaf
            if (j < N_IN) begin : g_used
                assign tree[N_LEAF+j] = W_TREE'(xnor_result[j]);
            end else begin : g_pad
                assign tree[N_LEAF+j] = '0;
            end
        end

        for (genvar k = 1; k < N_LEAF; k++) begin : g_add
            assign tree[k] = tree[2*k] + tree[2*k+1];
        end

        assign pop_d  = W_POP'(tree[1]);
        assign bias_d = weights[n];
        assign sum_d  = W_OUT'(pop_q) + W_OUT'(bias_q);

        // Stage 1 carries the bias alongside its popcount; stage 2 holds the sum.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pop_q  <= '0;
                bias_q <= '0;
                sum_q  <= '0;
            end else begin
                pop_q  <= pop_d;
                bias_q <= bias_d;
                sum_q  <= sum_d;
            end
        end

        assign fan_out[n] = sum_q;
    end

endmodule

// File: tb/tb_fully_connected.sv
// Scoreboard bench for fully_connected: model results queued at each sampling
// edge and compared against fan_out one edge later.
module tb_fully_connected;

    localparam int unsigned N_IN   = 960;
    localparam int unsigned N_OUT  = 10;
    localparam int unsigned W_BIAS = 8;
    localparam int unsigned W_OUT  = 17;

    typedef struct {
        logic [W_OUT-1:0] v [N_OUT];
    } exp_t;

    logic              clk;
    logic              rst;
    logic [N_IN-1:0]   fan_in;
    logic [W_BIAS-1:0] weights        [N_OUT];
    logic [N_IN-1:0]   binary_weights [N_OUT];
    logic [W_OUT-1:0]  fan_out        [N_OUT];

    exp_t sb[$];
    exp_t got;
    int   n_checks = 0;
    int   n_fail   = 0;

    fully_connected #(
        .N_IN(N_IN), .N_OUT(N_OUT), .W_BIAS(W_BIAS), .W_OUT(W_OUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fan_in(fan_in),
        .weights(weights),
        .binary_weights(binary_weights),
        .fan_out(fan_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N_IN-1:0] rand_vec();
        logic [N_IN-1:0] v;
        for (int w = 0; w < int'(N_IN / 32); w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic rand_inputs();
        fan_in = rand_vec();
        for (int i = 0; i < int'(N_OUT); i++) begin
            binary_weights[i] = rand_vec();
            weights[i]        = W_BIAS'($urandom_range(0, 255));
        end
    endtask

    // Queue the reference result for the inputs about to be sampled, then clock.
    task automatic push_and_tick();
        exp_t e;
        for (int i = 0; i < int'(N_OUT); i++)
            e.v[i] = W_OUT'($countones(~(fan_in ^ binary_weights[i]))) + W_OUT'(weights[i]);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // After reset release the first visible stage-2 value is a pipeline zero.
    task automatic restart_scoreboard();
        exp_t e;
        sb.delete();
        for (int i = 0; i < int'(N_OUT); i++) e.v[i] = '0;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rand_inputs();
        #3;
        for (int i = 0; i < int'(N_OUT); i++) begin
            n_checks++;
            if (fan_out[i] !== '0) begin
                n_fail++;
                $display("FAIL reset_async node %0d: got %0d expected 0", i, fan_out[i]);
            end
        end
        for (int c = 0; c < 2; c++) begin
            rand_inputs();
            @(posedge clk);
            #1;
            for (int i = 0; i < int'(N_OUT); i++) begin
                n_checks++;
                if (fan_out[i] !== '0) begin
                    n_fail++;
                    $display("FAIL reset_held node %0d: got %0d expected 0", i, fan_out[i]);
                end
            end
        end
        rst = 1'b0;
        restart_scoreboard();
        for (int c = 0; c < 3; c++) begin
            rand_inputs();
            push_and_tick();
            if (sb.size() >= 2) begin
                got = sb.pop_front();
                for (int i = 0; i < int'(N_OUT); i++) begin
                    n_checks++;
                    if (fan_out[i] !== got.v[i]) begin
                        n_fail++;
                        $display("FAIL post_reset node %0d: got %0d expected %0d", i, fan_out[i], got.v[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_all_match();
        for (int c = 0; c < 4; c++) begin
            fan_in = (c % 2 == 0) ? '1 : '0;
            for (int i = 0; i < int'(N_OUT); i++) begin
                binary_weights[i] = fan_in;
                weights[i]        = W_BIAS'(i);
            end
            push_and_tick();
            if (sb.size() >= 2) begin
                got = sb.pop_front();
                for (int i = 0; i < int'(N_OUT); i++) begin
                    n_checks++;
                    if (fan_out[i] !== got.v[i]) begin
                        n_fail++;
                        $display("FAIL all_match node %0d: got %0d expected %0d", i, fan_out[i], got.v[i]);
                    end
                end
            end
        end
        // Held all-match inputs: the registered output must be 960 + i exactly.
        push_and_tick();
        got = sb.pop_front();
        for (int i = 0; i < int'(N_OUT); i++) begin
            n_checks++;
            if (fan_out[i] !== W_OUT'(960 + i)) begin
                n_fail++;
                $display("FAIL all_match_const node %0d: got %0d expected %0d", i, fan_out[i], 960 + i);
            end
        end
    endtask

    task automatic test_all_mismatch();
        logic [W_BIAS-1:0] bias;
        for (int c = 0; c < 4; c++) begin
            bias   = (c < 2) ? 8'd255 : 8'd0;
            fan_in = '1;
            for (int i = 0; i < int'(N_OUT); i++) begin
                binary_weights[i] = '0;
                weights[i]        = bias;
            end
            push_and_tick();
            if (sb.size() >= 2) begin
                got = sb.pop_front();
                for (int i = 0; i < int'(N_OUT); i++) begin
                    n_checks++;
                    if (fan_out[i] !== got.v[i]) begin
                        n_fail++;
                        $display("FAIL all_mismatch node %0d: got %0d expected %0d", i, fan_out[i], got.v[i]);
                    end
                end
            end
            if (c == 1 || c == 3) begin
                for (int i = 0; i < int'(N_OUT); i++) begin
                    n_checks++;
                    if (fan_out[i] !== W_OUT'(bias)) begin
                        n_fail++;
                        $display("FAIL mismatch_bias node %0d: got %0d expected %0d", i, fan_out[i], bias);
                    end
                end
            end
        end
    endtask

    task automatic test_partial_match();
        fan_in = '1;
        for (int i = 0; i < int'(N_OUT); i++) begin
            binary_weights[i] = '0;
            // 37 is coprime with 960, so these positions are all distinct.
            for (int j = 0; j < 100*i + 3; j++) binary_weights[i][(j*37 + i*11) % 960] = 1'b1;
            weights[i] = 8'd10;
        end
        for (int c = 0; c < 2; c++) begin
            push_and_tick();
            if (sb.size() >= 2) begin
                got = sb.pop_front();
                for (int i = 0; i < int'(N_OUT); i++) begin
                    n_checks++;
                    if (fan_out[i] !== got.v[i]) begin
                        n_fail++;
                        $display("FAIL partial node %0d: got %0d expected %0d", i, fan_out[i], got.v[i]);
                    end
                end
            end
        end
        for (int i = 0; i < int'(N_OUT); i++) begin
            n_checks++;
            if (fan_out[i] !== W_OUT'(100*i + 13)) begin
                n_fail++;
                $display("FAIL partial_const node %0d: got %0d expected %0d", i, fan_out[i], 100*i + 13);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 6; c++) begin
            if (c % 2 == 0) begin
                fan_in = '1;
                for (int i = 0; i < int'(N_OUT); i++) begin
                    binary_weights[i] = '1;
                    weights[i]        = 8'd5;
                end
            end else begin
                fan_in = '0;
                for (int i = 0; i < int'(N_OUT); i++) begin
                    binary_weights[i] = '1;
                    weights[i]        = W_BIAS'(7 + i);
                end
            end
            push_and_tick();
            if (sb.size() >= 2) begin
                got = sb.pop_front();
                for (int i = 0; i < int'(N_OUT); i++) begin
                    n_checks++;
                    if (fan_out[i] !== got.v[i]) begin
                        n_fail++;
                        $display("FAIL back_to_back node %0d: got %0d expected %0d", i, fan_out[i], got.v[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1000; c++) begin
            if (c == 500) begin
                #1 rst = 1'b1;
                #1;
                for (int r = 0; r < 3; r++) begin
                    for (int i = 0; i < int'(N_OUT); i++) begin
                        n_checks++;
                        if (fan_out[i] !== '0) begin
                            n_fail++;
                            $display("FAIL mid_reset node %0d: got %0d expected 0", i, fan_out[i]);
                        end
                    end
                    rand_inputs();
                    @(posedge clk);
                    #1;
                end
                rst = 1'b0;
                restart_scoreboard();
            end
            rand_inputs();
            push_and_tick();
            if (sb.size() >= 2) begin
                got = sb.pop_front();
                for (int i = 0; i < int'(N_OUT); i++) begin
                    n_checks++;
                    if (fan_out[i] !== got.v[i]) begin
                        n_fail++;
                        $display("FAIL random node %0d: got %0d expected %0d", i, fan_out[i], got.v[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_match();
        test_all_mismatch();
        test_partial_match();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fully_connected.md
Name: fully_connected

Overview:
Binarized fully-connected (dense) layer, used as the final classifier stage of the BNN datapath. Each output node compares the 960-bit binary activation vector with its own 960-bit binary weight vector using XNOR. It counts the matching bits (popcount) and adds that node's 8-bit bias. Ten nodes are computed in parallel, and the results are registered through a fixed 2-stage pipeline.

Parameters:
N_IN, 960, number of binary inputs per node (fan_in width).
N_OUT, 10, number of output nodes.
W_BIAS, 8, bias width (unsigned).
W_OUT, 17, output word width.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
fan_in  input  N_IN  binary activation vector; bit j is input j (bit 1 = +1, bit 0 = -1).
weights  input  [W_BIAS-1:0] x N_OUT (unpacked array)  per-node bias, unsigned.
binary_weights  input  [N_IN-1:0] x N_OUT (unpacked array)  per-node binary weight vector, bit-aligned with fan_in.
fan_out  output  [W_OUT-1:0] x N_OUT (unpacked array)  per-node result.

Behaviour:
- Reset: clk single clock; rst asynchronous active-high. While rst=1:
  - every pipeline register and every fan_out[i] is forced to 0 immediately, without waiting for a clock edge;
  - all registers hold 0 until the first rising clk edge after rst deasserts.
- Per node i (0..N_OUT-1):
  - xnor_result[i] = ~(fan_in ^ binary_weights[i]), N_IN bits, combinational.
  - accumulation_result[i] = number of 1s in xnor_result[i].
    - Range 0..960, computed as an unsigned 10-bit value ($clog2(N_IN+1)).
  - accumulation_after_bias[i] = zero-extend(accumulation_result[i]) + zero-extend(weights[i]).
    - Computed in W_OUT bits; maximum 960+255 = 1215, so no overflow or saturation.
- Pipeline, fixed latency 2 cycles:
  - Stage 1 (posedge clk): register accumulation_result[i] for all nodes and register weights[i] alongside it, so the bias is aligned with its popcount.
  - Stage 2 (posedge clk): fan_out[i] <= stage-1 popcount + stage-1 bias.
- Inputs sampled at edge k appear on fan_out after edge k+1. A new input may be applied every cycle (throughput 1/cycle).
- No handshake. Inputs are sampled every cycle and fan_out always reflects inputs from two edges earlier.
- Nodes are fully independent; no cross-node arithmetic.
- The popcount is a balanced adder tree and need not be pipelined further. The bias add happens after the full popcount.
- Boundaries:
  - all bits match gives popcount 960;
  - all bits differ gives popcount 0;
  - bias 0 and bias 255 must both be handled exactly.
- Reset mid-operation: in-flight data is discarded. fan_out returns to 0 and stays 0 until two edges after rst deasserts. During those two edges, fan_out shows only pipeline zeros, never stale values.
- X-propagation: none is introduced internally. Known inputs must yield fully known outputs two edges after reset release.

Test Plan:
- Reset: rst=1 with arbitrary inputs applied -> all fan_out[i]==0 immediately, with no clock edge needed. Release rst; after 2 edges, outputs are valid.
- All match: fan_in=all 1s, binary_weights[i]=all 1s, weights[i]=i -> fan_out[i]==960+i after 2 edges. Repeat with fan_in and weights all 0s -> same result.
- All mismatch: fan_in=all 1s, binary_weights[i]=all 0s, weights[i]=255 -> fan_out[i]==255. With bias 0 -> fan_out[i]==0.
- Partial match: fan_in=all 1s, binary_weights[i] has exactly 100*i+3 ones at scattered positions, weights[i]=10 -> fan_out[i]==100*i+13. Node i is checked independently of its neighbours.
- Pipeline/throughput: apply vector A at edge k and vector B at edge k+1 -> fan_out holds A's result after edge k+1 and B's result after edge k+2, with no bubble.
- Random: 1000 random cycles of fan_in, binary_weights and weights -> every fan_out[i] equals the reference model (popcount of XNOR plus bias) from two cycles earlier. Include rst asserted mid-stream and check zeros while it is asserted.
